// File: rtl/mem2axi_pkg.sv
// Shared types and AXI constants for the memory-port to AXI4 master bridge.
package mem2axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      AW_W,
      B
   } state_e;

   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // SLVERR and DECERR are the only codes with the upper bit set.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle shared by the bridge and its interconnect neighbours.
interface AXI_BUS #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_USER_WIDTH = 1
);
   localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

   logic [AXI_ID_WIDTH-1:0]   aw_id;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [7:0]                aw_len;
   logic [2:0]                aw_size;
   logic [1:0]                aw_burst;
   logic                      aw_lock;
   logic [3:0]                aw_cache;
   logic [2:0]                aw_prot;
   logic [3:0]                aw_qos;
   logic [3:0]                aw_region;
   logic [AXI_USER_WIDTH-1:0] aw_user;
   logic                      aw_valid;
   logic                      aw_ready;

   logic [AXI_DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0]     w_strb;
   logic                      w_last;
   logic [AXI_USER_WIDTH-1:0] w_user;
   logic                      w_valid;
   logic                      w_ready;

   logic [AXI_ID_WIDTH-1:0]   b_id;
   logic [1:0]                b_resp;
   logic [AXI_USER_WIDTH-1:0] b_user;
   logic                      b_valid;
   logic                      b_ready;

   logic [AXI_ID_WIDTH-1:0]   ar_id;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr;
   logic [7:0]                ar_len;
   logic [2:0]                ar_size;
   logic [1:0]                ar_burst;
   logic                      ar_lock;
   logic [3:0]                ar_cache;
   logic [2:0]                ar_prot;
   logic [3:0]                ar_qos;
   logic [3:0]                ar_region;
   logic [AXI_USER_WIDTH-1:0] ar_user;
   logic                      ar_valid;
   logic                      ar_ready;

   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [AXI_DATA_WIDTH-1:0] r_data;
   logic [1:0]                r_resp;
   logic                      r_last;
   logic [AXI_USER_WIDTH-1:0] r_user;
   logic                      r_valid;
   logic                      r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/mem2axi.sv
// Core-side req/gnt/rvalid port to single-beat AXI4 master, one access in flight.
// Define MEM2AXI_ERR_EN to add mem_err_o, reporting SLVERR/DECERR responses.
module mem2axi
   import mem2axi_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ID         = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mem_req_i,
   output logic                      mem_gnt_o,
   input  logic [AXI_ADDR_WIDTH-1:0] mem_addr_i,
   input  logic                      mem_we_i,
   input  logic [3:0]                mem_be_i,
   input  logic [31:0]               mem_wdata_i,
   output logic                      mem_rvalid_o,
   output logic [31:0]               mem_rdata_o,
`ifdef MEM2AXI_ERR_EN
   output logic                      mem_err_o,
`endif
   AXI_BUS.Master                    master
);

   state_e                    state, state_next;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic                      we_q;
   logic [3:0]                be_q;
   logic [31:0]               wdata_q;
   logic                      aw_done, w_done;
   logic                      rvalid_q;
   logic [31:0]               rdata_q;
   logic                      ar_valid, r_ready, aw_valid, w_valid, b_ready;
   logic                      aw_hs, w_hs, r_hs, b_hs;

   assign aw_hs = aw_valid & master.aw_ready;
   assign w_hs  = w_valid  & master.w_ready;
   assign r_hs  = r_ready  & master.r_valid;
   assign b_hs  = b_ready  & master.b_valid;

   // Gating with rst_n keeps the grant low while reset is held, not just after an edge.
   assign mem_gnt_o = rst_n & (state == IDLE) & mem_req_i;

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_next = state;
      ar_valid   = 1'b0;
      r_ready    = 1'b0;
      aw_valid   = 1'b0;
      w_valid    = 1'b0;
      b_ready    = 1'b0;
      case (state)
         IDLE: if (mem_req_i) state_next = mem_we_i ? AW_W : AR;
         AR: begin
            ar_valid = 1'b1;
            if (master.ar_ready) state_next = R;
         end
         R: begin
            r_ready = 1'b1;
            if (master.r_valid) state_next = IDLE;
         end
         AW_W: begin
            aw_valid = ~aw_done;
            w_valid  = ~w_done;
            if ((aw_done | master.aw_ready) & (w_done | master.w_ready)) state_next = B;
         end
         B: begin
            b_ready = 1'b1;
            if (master.b_valid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: payload registers are reset as well so the AXI fields never leave reset as X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (mem_gnt_o) begin
            addr_q  <= mem_addr_i;
            we_q    <= mem_we_i;
            be_q    <= mem_be_i;
            wdata_q <= mem_wdata_i;
         end
         if (state == AW_W) begin
            if (state_next == B) begin
               aw_done <= 1'b0;
               w_done  <= 1'b0;
            end else begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
            end
         end
         rvalid_q <= r_hs | b_hs;
         if (r_hs) rdata_q <= master.r_data;
      end
   end

`ifdef MEM2AXI_ERR_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    err_q <= 1'b0;
      else if (r_hs) err_q <= resp_is_err(master.r_resp);
      else if (b_hs) err_q <= resp_is_err(master.b_resp);
   end

   assign mem_err_o = err_q;

   logic unused_fields;
   assign unused_fields = ^{we_q, master.r_id, master.b_id, master.r_last,
                            master.r_user, master.b_user};
`else
   logic unused_fields;
   assign unused_fields = ^{we_q, master.r_id, master.b_id, master.r_last,
                            master.r_user, master.b_user, master.r_resp, master.b_resp};
`endif

   assign mem_rvalid_o = rvalid_q;
   assign mem_rdata_o  = rdata_q;

   assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
   assign master.aw_addr   = addr_q;
   assign master.aw_len    = 8'd0;
   assign master.aw_size   = AXI_SIZE_WORD;
   assign master.aw_burst  = AXI_BURST_INCR;
   assign master.aw_lock   = 1'b0;
   assign master.aw_cache  = 4'd0;
   assign master.aw_prot   = 3'd0;
   assign master.aw_qos    = 4'd0;
   assign master.aw_region = 4'd0;
   assign master.aw_user   = '0;
   assign master.aw_valid  = aw_valid;

   assign master.w_data    = wdata_q;
   assign master.w_strb    = be_q;
   assign master.w_last    = 1'b1;
   assign master.w_user    = '0;
   assign master.w_valid   = w_valid;

   assign master.b_ready   = b_ready;

   assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
   assign master.ar_addr   = addr_q;
   assign master.ar_len    = 8'd0;
   assign master.ar_size   = AXI_SIZE_WORD;
   assign master.ar_burst  = AXI_BURST_INCR;
   assign master.ar_lock   = 1'b0;
   assign master.ar_cache  = 4'd0;
   assign master.ar_prot   = 3'd0;
   assign master.ar_qos    = 4'd0;
   assign master.ar_region = 4'd0;
   assign master.ar_user   = '0;
   assign master.ar_valid  = ar_valid;

   assign master.r_ready   = r_ready;

endmodule

// File: tb/tb_mem2axi.sv
// Bench for mem2axi: bench-side AXI slave with tunable delays, word-memory reference model.
module tb_mem2axi;
   import mem2axi_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        mem_req_i, mem_gnt_o, mem_we_i, mem_rvalid_o;
   logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
   logic [3:0]  mem_be_i;
`ifdef MEM2AXI_ERR_EN
   logic        mem_err_o;
`endif

   AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(1)) axi ();

   mem2axi #(.AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(10), .AXI_ID(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_req_i    (mem_req_i),
      .mem_gnt_o    (mem_gnt_o),
      .mem_addr_i   (mem_addr_i),
      .mem_we_i     (mem_we_i),
      .mem_be_i     (mem_be_i),
      .mem_wdata_i  (mem_wdata_i),
      .mem_rvalid_o (mem_rvalid_o),
      .mem_rdata_o  (mem_rdata_o),
`ifdef MEM2AXI_ERR_EN
      .mem_err_o    (mem_err_o),
`endif
      .master       (axi)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: 8-word memory indexed by address bits [4:2].
   logic [31:0] ref_mem [8];
   logic [31:0] slave_mem [8];
   bit          busy;
   logic        cur_we;
   logic [31:0] cur_addr, cur_wdata, exp_rdata, last_rdata;
   logic [3:0]  cur_be;
   logic        exp_err;

   // Driver and slave knobs.
   logic        req_drv, we_drv;
   logic [31:0] addr_drv, data_drv;
   logic [3:0]  be_drv;
   int ar_dly, aw_dly, w_dly, r_dly, b_dly, resp_sel;
   int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
   bit r_pend, b_pend, aw_got, w_got;
   logic [2:0]  r_idx;
   logic [31:0] aw_addr_s, w_data_s;
   logic [3:0]  w_strb_s;
   logic [1:0]  r_resp_s, b_resp_s;

   int cyc, gnt_cyc, rv_cyc, ar_hs_cyc, aw_hs_cyc, w_hs_cyc, r_hs_cyc, b_hs_cyc, rv_total;
   bit gnt_seen, rv_seen;
   bit p_arv, p_awv, p_wv;
   logic [31:0] p_ar_addr, p_aw_addr, p_wdata;
   logic [3:0]  p_wstrb;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] res = old;
      for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = d[8*i +: 8];
      return res;
   endfunction

   function automatic logic [1:0] pick_resp();
      if (resp_sel >= 0) return 2'(resp_sel);
      return 2'($urandom_range(0, 3));
   endfunction

   task automatic reset_model();
      busy = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      p_arv = 0; p_awv = 0; p_wv = 0;
      last_rdata = 32'd0; exp_err = 1'b0;
   endtask

   task automatic set_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] data);
      req_drv = 1'b1; we_drv = we; addr_drv = addr; be_drv = be; data_drv = data;
   endtask

   // One clock cycle: drive at the falling edge, sample 1 ns later, update the models.
   task automatic step();
      bit ar_hs, aw_hs, w_hs, r_hs, b_hs;
      @(negedge clk);
      cyc++;
      gnt_seen = 0;
      rv_seen  = 0;
      axi.ar_ready = (ar_cnt >= ar_dly);
      axi.aw_ready = (aw_cnt >= aw_dly);
      axi.w_ready  = (w_cnt >= w_dly);
      axi.r_valid  = r_pend && (r_cnt >= r_dly);
      axi.r_data   = slave_mem[r_idx];
      axi.r_resp   = r_resp_s;
      axi.r_id     = 10'($urandom);
      axi.r_last   = 1'($urandom);
      axi.b_valid  = b_pend && (b_cnt >= b_dly);
      axi.b_resp   = b_resp_s;
      axi.b_id     = 10'($urandom);
      mem_req_i    = req_drv;
      mem_we_i     = we_drv;
      mem_addr_i   = addr_drv;
      mem_be_i     = be_drv;
      mem_wdata_i  = data_drv;
      #1;

      if (p_arv) begin
         check("ar_valid_stable", axi.ar_valid, 1);
         check("ar_addr_stable", axi.ar_addr, p_ar_addr);
      end
      if (p_awv) begin
         check("aw_valid_stable", axi.aw_valid, 1);
         check("aw_addr_stable", axi.aw_addr, p_aw_addr);
      end
      if (p_wv) begin
         check("w_valid_stable", axi.w_valid, 1);
         check("w_payload_stable", {axi.w_strb, axi.w_data}, {p_wstrb, p_wdata});
      end
      check("ar_aw_overlap", axi.ar_valid & axi.aw_valid, 0);

      if (mem_rvalid_o) begin
         rv_seen = 1; rv_cyc = cyc; rv_total++;
         check("rvalid_outstanding", busy, 1);
         check("rdata", mem_rdata_o, cur_we ? last_rdata : exp_rdata);
`ifdef MEM2AXI_ERR_EN
         check("err", mem_err_o, exp_err);
`endif
         if (!cur_we) last_rdata = exp_rdata;
         busy = 0;
      end

      check("gnt", mem_gnt_o, req_drv && !busy);
      if (mem_gnt_o && req_drv) begin
         gnt_seen = 1; gnt_cyc = cyc; busy = 1;
         cur_we = we_drv; cur_addr = addr_drv; cur_be = be_drv; cur_wdata = data_drv;
         if (we_drv) ref_mem[addr_drv[4:2]] = merge(ref_mem[addr_drv[4:2]], data_drv, be_drv);
         else        exp_rdata = ref_mem[addr_drv[4:2]];
      end

      ar_hs = axi.ar_valid && axi.ar_ready;
      aw_hs = axi.aw_valid && axi.aw_ready;
      w_hs  = axi.w_valid && axi.w_ready;
      r_hs  = axi.r_valid && axi.r_ready;
      b_hs  = axi.b_valid && axi.b_ready;

      if (r_hs) begin
         r_pend = 0; r_hs_cyc = cyc; exp_err = r_resp_s[1];
      end
      if (b_hs) begin
         b_pend = 0; b_hs_cyc = cyc; exp_err = b_resp_s[1];
      end
      if (r_pend) r_cnt++;
      if (b_pend) b_cnt++;

      if (ar_hs) begin
         ar_hs_cyc = cyc;
         check("ar_kind", {busy, cur_we}, 2'b10);
         check("ar_addr", axi.ar_addr, cur_addr);
         check("ar_fields", {axi.ar_id, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_lock,
                             axi.ar_cache, axi.ar_prot, axi.ar_qos, axi.ar_region},
               {10'd5, 8'd0, AXI_SIZE_WORD, AXI_BURST_INCR, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
         r_pend = 1; r_cnt = 0; r_idx = axi.ar_addr[4:2]; r_resp_s = pick_resp();
      end
      if (aw_hs) begin
         aw_hs_cyc = cyc;
         check("aw_kind", {busy, cur_we}, 2'b11);
         check("aw_addr", axi.aw_addr, cur_addr);
         check("aw_fields", {axi.aw_id, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_lock,
                             axi.aw_cache, axi.aw_prot, axi.aw_qos, axi.aw_region},
               {10'd5, 8'd0, AXI_SIZE_WORD, AXI_BURST_INCR, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
         aw_got = 1; aw_addr_s = axi.aw_addr;
      end
      if (w_hs) begin
         w_hs_cyc = cyc;
         check("w_beat", {axi.w_last, axi.w_strb, axi.w_data}, {1'b1, cur_be, cur_wdata});
         w_got = 1; w_data_s = axi.w_data; w_strb_s = axi.w_strb;
      end
      if (aw_got && w_got) begin
         slave_mem[aw_addr_s[4:2]] = merge(slave_mem[aw_addr_s[4:2]], w_data_s, w_strb_s);
         aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; b_resp_s = pick_resp();
      end

      ar_cnt = (axi.ar_valid && !ar_hs) ? ar_cnt + 1 : 0;
      aw_cnt = (axi.aw_valid && !aw_hs) ? aw_cnt + 1 : 0;
      w_cnt  = (axi.w_valid && !w_hs) ? w_cnt + 1 : 0;
      p_arv = axi.ar_valid && !ar_hs; p_ar_addr = axi.ar_addr;
      p_awv = axi.aw_valid && !aw_hs; p_aw_addr = axi.aw_addr;
      p_wv  = axi.w_valid && !w_hs;   p_wdata = axi.w_data; p_wstrb = axi.w_strb;
   endtask

   task automatic wait_gnt(input string tag);
      int n = 0;
      do begin step(); n++; end while (!gnt_seen && n < 200);
      check(tag, gnt_seen, 1);
   endtask

   task automatic wait_rv(input string tag);
      int n = 0;
      do begin step(); n++; end while (!rv_seen && n < 200);
      check(tag, rv_seen, 1);
   endtask

   int t0, n0;

   initial begin
      rst_n = 1'b0;
      req_drv = 0; we_drv = 0; addr_drv = 0; be_drv = 0; data_drv = 0;
      ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0; resp_sel = 0;
      r_idx = 0; r_resp_s = 0; b_resp_s = 0; cyc = 0; rv_total = 0;
      cur_we = 0; exp_rdata = 0;
      axi.ar_ready = 0; axi.aw_ready = 0; axi.w_ready = 0; axi.r_valid = 0; axi.b_valid = 0;
      axi.r_data = 0; axi.r_resp = 0; axi.r_id = 0; axi.r_last = 0; axi.r_user = 0;
      axi.b_resp = 0; axi.b_id = 0; axi.b_user = 0;
      mem_we_i = 0; mem_addr_i = 0; mem_be_i = 0; mem_wdata_i = 0;
      for (int i = 0; i < 8; i++) begin
         ref_mem[i] = $urandom;
         slave_mem[i] = ref_mem[i];
      end
      reset_model();
      mem_req_i = 1'b1;
      #12;
      check("rst_gnt", mem_gnt_o, 0);
      check("rst_rvalid", mem_rvalid_o, 0);
      check("rst_rdata", mem_rdata_o, 0);
      check("rst_valids", {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready}, 0);
`ifdef MEM2AXI_ERR_EN
      check("rst_err", mem_err_o, 0);
`endif
      mem_req_i = 1'b0;
      #10 rst_n = 1'b1;
      repeat (2) step();

      // Read with every ready high.
      ref_mem[0] = 32'hDEADBEEF; slave_mem[0] = 32'hDEADBEEF;
      set_req(0, 32'h1000, 4'h0, 32'h0);
      wait_gnt("t1_gnt"); t0 = gnt_cyc; req_drv = 0;
      wait_rv("t1_rv");
      check("t1_ar_cycle", ar_hs_cyc - t0, 1);
      check("t1_r_cycle", r_hs_cyc - t0, 2);
      check("t1_rv_cycle", rv_cyc - t0, 3);
      check("t1_rdata", mem_rdata_o, 32'hDEADBEEF);

      // Write, AW ready delayed three cycles.
      aw_dly = 3;
      set_req(1, 32'h2004, 4'b0011, 32'h0000A5A5);
      wait_gnt("t2_gnt"); t0 = gnt_cyc; req_drv = 0;
      wait_rv("t2_rv");
      check("t2_w_cycle", w_hs_cyc - t0, 1);
      check("t2_aw_cycle", aw_hs_cyc - t0, 4);
      check("t2_b_cycle", b_hs_cyc - t0, 5);
      check("t2_rv_cycle", rv_cyc - t0, 6);

      // W before AW, slow B, request held so the next read is granted at the rvalid cycle.
      aw_dly = 2; b_dly = 5;
      set_req(1, 32'h108, 4'b1100, 32'h12345678);
      wait_gnt("t3_gnt"); t0 = gnt_cyc; n0 = rv_total;
      set_req(0, 32'h108, 4'h0, 32'h0);
      wait_gnt("t3_gnt2");
      check("t3_w_first", w_hs_cyc - t0, 1);
      check("t3_aw_after", aw_hs_cyc - t0, 3);
      check("t3_b_cycle", b_hs_cyc - t0, 9);
      check("t3_one_rv", rv_total - n0, 1);
      check("t3_gnt_at_rv", gnt_cyc, rv_cyc);
      req_drv = 0; aw_dly = 0; b_dly = 0;
      wait_rv("t3_rv2");

      // Read then write back to back.
      set_req(0, 32'h10C, 4'h0, 32'h0);
      wait_gnt("t4_gnt"); t0 = gnt_cyc;
      set_req(1, 32'h10C, 4'b0101, 32'hCAFEF00D);
      wait_gnt("t4_gnt2");
      check("t4_gnt_at_rv", gnt_cyc, rv_cyc);
      check("t4_gnt2_cycle", gnt_cyc - t0, 3);
      req_drv = 0;
      wait_rv("t4_rv2");

      // Reset while AR is stalled.
      ar_dly = 50;
      set_req(0, 32'h110, 4'h0, 32'h0);
      wait_gnt("t5_gnt"); req_drv = 0;
      step();
      check("t5_ar_pending", axi.ar_valid, 1);
      #2 rst_n = 1'b0;
      mem_req_i = 1'b1;
      #1;
      check("t5_valids", {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready}, 0);
      check("t5_gnt", mem_gnt_o, 0);
      check("t5_rvalid", mem_rvalid_o, 0);
      mem_req_i = 1'b0;
      reset_model();
      ar_dly = 0;
      #4 rst_n = 1'b1;
      step();
      set_req(0, 32'h114, 4'h0, 32'h0);
      wait_gnt("t5_gnt2"); t0 = gnt_cyc; req_drv = 0;
      wait_rv("t5_rv");
      check("t5_rv_cycle", rv_cyc - t0, 3);

`ifdef MEM2AXI_ERR_EN
      resp_sel = int'(RESP_SLVERR);
      set_req(0, 32'h118, 4'h0, 32'h0);
      wait_gnt("t6_gnt"); req_drv = 0;
      wait_rv("t6_rv");
      check("t6_err_read", mem_err_o, 1);
      resp_sel = int'(RESP_OKAY);
      set_req(1, 32'h118, 4'hF, 32'h0BADC0DE);
      wait_gnt("t6_gnt2"); req_drv = 0;
      wait_rv("t6_rv2");
      check("t6_err_write", mem_err_o, 0);
`endif

      // Random traffic with random channel delays and responses.
      resp_sel = -1;
      for (int k = 0; k < 200; k++) begin
         ar_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 3);
         w_dly  = $urandom_range(0, 3); r_dly  = $urandom_range(0, 3);
         b_dly  = $urandom_range(0, 3);
         set_req(1'($urandom), 32'h100 + 32'($urandom_range(0, 7)) * 4, 4'($urandom), $urandom);
         wait_gnt("rnd_gnt");
         req_drv = 0;
         wait_rv("rnd_rv");
         repeat ($urandom_range(0, 2)) step();
      end

      check("final_idle", busy, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
